// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and the
// MUL/DIV start/done handshake with a timeout watchdog and saturating
// stall/flush statistics.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_RUN      | normal flow; load-use stall, branch flush or MDU launch
// S_MDU_WAIT | MDU busy; pipeline held until mdu_done or timeout
// S_ERROR    | MDU timed out; pipeline frozen until reset
module hazard_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rd,
    input  logic             EX_is_mdu,
    input  logic             EX_branch_taken,
    input  logic             mdu_done,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             mdu_start,
    output logic             mdu_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WC_W = $clog2(MDU_TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MDU_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MDU_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            error_set;
    logic            load_use;
    logic            stall_inc;
    logic            flush_inc;

    // Forwarding cannot cover a load result needed by the very next instruction.
    always_comb begin
        load_use = EX_MemRead && (EX_rd != 5'd0) &&
                   ((ID_use_rs1 && (ID_rs1 == EX_rd)) ||
                    (ID_use_rs2 && (ID_rs2 == EX_rd)));
    end

    // Next-state and pipeline control decode.
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Write  = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Flush = 1'b0;
        mdu_start    = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        error_set    = 1'b0;

        case (state)
            S_RUN: begin
                if (EX_is_mdu) begin
                    mdu_start    = 1'b1;
                    PC_Write     = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Write  = 1'b0;
                    EX_MEM_Flush = 1'b1;
                    state_nxt    = S_MDU_WAIT;
                    wait_cnt_nxt = '0;
                end else if (EX_branch_taken) begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                end else if (load_use) begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                end
            end
            S_MDU_WAIT: begin
                if (mdu_done) begin
                    state_nxt = S_RUN;
                end else begin
                    PC_Write     = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Write  = 1'b0;
                    EX_MEM_Flush = 1'b1;
                    wait_cnt_nxt = wait_cnt + WC_W'(1);
                    if (wait_cnt == WAIT_LAST) begin
                        error_set = 1'b1;
                        state_nxt = S_ERROR;
                    end
                end
            end
            S_ERROR: begin
                PC_Write     = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Write  = 1'b0;
                EX_MEM_Flush = 1'b1;
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    // State register, watchdog counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RUN;
            wait_cnt  <= '0;
            mdu_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mdu_error <= mdu_error | error_set;
        end
    end

    // A frozen pipeline in ERROR is not a stall worth counting.
    always_comb begin
        stall_inc = !PC_Write && (state != S_ERROR);
        flush_inc = IF_ID_Flush;
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_inc && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            if (flush_inc && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: table of single-cycle vectors plus hand-built
// MDU, timeout, reset and saturation sequences, checked via a scoreboard queue.
module tb_hazard_ctrl;

    localparam int TMO   = 4;
    localparam int CW    = 3;
    localparam int CMAX  = (1 << CW) - 1;

    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Flush, mdu_start}
    localparam logic [6:0] DEF  = 7'b1101000;
    localparam logic [6:0] LU   = 7'b0001100;
    localparam logic [6:0] BR   = 7'b1111100;
    localparam logic [6:0] MST  = 7'b0000011;
    localparam logic [6:0] HOLD = 7'b0000010;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       memread;
        logic [4:0] rd;
        logic       is_mdu;
        logic       taken;
        logic       done;
        logic [6:0] exp_ctrl;
        logic       exp_err;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    ID_rs1, ID_rs2, EX_rd;
    logic          ID_use_rs1, ID_use_rs2, EX_MemRead, EX_is_mdu, EX_branch_taken, mdu_done;
    logic          PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Flush;
    logic          mdu_start, mdu_error;
    logic [CW-1:0] stall_count, flush_count;
    logic [6:0]    ctrl_act;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   m_stall = 0;
    int   m_flush = 0;
    vec_t sb_q[$];
    vec_t tbl[11];

    hazard_ctrl #(.MDU_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .EX_MemRead(EX_MemRead), .EX_rd(EX_rd),
        .EX_is_mdu(EX_is_mdu), .EX_branch_taken(EX_branch_taken),
        .mdu_done(mdu_done),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Flush(EX_MEM_Flush),
        .mdu_start(mdu_start), .mdu_error(mdu_error),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    assign ctrl_act = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
                       ID_EX_Flush, EX_MEM_Flush, mdu_start};

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic use1, input logic use2,
                                input logic memread, input logic [4:0] rd,
                                input logic is_mdu, input logic taken, input logic done,
                                input logic [6:0] ctrl, input logic err);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2;
        v.memread = memread; v.rd = rd; v.is_mdu = is_mdu;
        v.taken = taken; v.done = done; v.exp_ctrl = ctrl; v.exp_err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        ID_rs1 = '0; ID_rs2 = '0; ID_use_rs1 = 0; ID_use_rs2 = 0;
        EX_MemRead = 0; EX_rd = '0; EX_is_mdu = 0; EX_branch_taken = 0; mdu_done = 0;
    endtask

    // Called at posedge+#1; asserts reset asynchronously and checks it acts at once.
    task automatic do_reset(input string nm);
        clear_inputs();
        rst = 1'b1;
        #1;
        chk({nm, ".ctrl"},  32'(ctrl_act),    32'(DEF));
        chk({nm, ".err"},   32'(mdu_error),   32'd0);
        chk({nm, ".stall"}, 32'(stall_count), 32'd0);
        chk({nm, ".flush"}, 32'(flush_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare at negedge.
    task automatic step(input vec_t v, input string nm);
        vec_t e;
        ID_rs1 = v.rs1; ID_rs2 = v.rs2; ID_use_rs1 = v.use1; ID_use_rs2 = v.use2;
        EX_MemRead = v.memread; EX_rd = v.rd; EX_is_mdu = v.is_mdu;
        EX_branch_taken = v.taken; mdu_done = v.done;
        sb_q.push_back(v);
        @(negedge clk);
        e = sb_q.pop_front();
        chk({nm, ".ctrl"},  32'(ctrl_act),    32'(e.exp_ctrl));
        chk({nm, ".err"},   32'(mdu_error),   32'(e.exp_err));
        chk({nm, ".stall"}, 32'(stall_count), 32'(m_stall));
        chk({nm, ".flush"}, 32'(flush_count), 32'(m_flush));
        if (!e.exp_ctrl[6] && !e.exp_err && m_stall < CMAX) m_stall++;
        if (e.exp_ctrl[4] && m_flush < CMAX) m_flush++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;

        //               rs1 rs2 u1 u2 ld rd  mdu br dn  ctrl  err
        tbl[0]  = mk(0,  0,  0, 0, 0, 0,  0, 0, 0, DEF, 0);
        tbl[1]  = mk(0,  5,  0, 1, 1, 5,  0, 0, 0, LU,  0);
        tbl[2]  = mk(0,  0,  0, 0, 0, 0,  0, 0, 0, DEF, 0);
        tbl[3]  = mk(0,  0,  1, 0, 1, 0,  0, 0, 0, DEF, 0);
        tbl[4]  = mk(7,  0,  0, 0, 1, 7,  0, 0, 0, DEF, 0);
        tbl[5]  = mk(0,  7,  1, 0, 1, 7,  0, 0, 0, DEF, 0);
        tbl[6]  = mk(9,  0,  1, 0, 1, 9,  0, 0, 0, LU,  0);
        tbl[7]  = mk(9,  0,  1, 0, 0, 9,  0, 0, 0, DEF, 0);
        tbl[8]  = mk(0,  0,  0, 0, 0, 0,  0, 1, 0, BR,  0);
        tbl[9]  = mk(3,  0,  1, 0, 1, 3,  0, 1, 0, BR,  0);
        tbl[10] = mk(0,  0,  0, 0, 0, 0,  0, 0, 1, DEF, 0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // Branch beats a simultaneous load-use hazard, counted from a clean reset.
        do_reset("rst_br");
        step(mk(3, 0, 1, 0, 1, 3, 0, 1, 0, BR,  0), "br_lu");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0), "br_lu_after");
        chk("br_lu.flush_count", 32'(flush_count), 32'd1);
        chk("br_lu.stall_count", 32'(stall_count), 32'd0);

        // MDU op: done held during start (ignored), done again 4 cycles after start.
        do_reset("rst_mdu");
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, MST,  0), "mdu_start");
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD, 0), "mdu_w1");
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD, 0), "mdu_w2");
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD, 0), "mdu_w3");
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, DEF,  0), "mdu_done");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, DEF,  0), "mdu_after");
        chk("mdu.stall_count", 32'(stall_count), 32'd4);

        // Timeout: exactly TMO wait cycles, then ERROR freezes the pipeline.
        do_reset("rst_tmo");
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, MST, 0), "tmo_start");
        for (int i = 0; i < TMO; i++)
            step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD, 0), $sformatf("tmo_w%0d", i));
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD, 1), "err_hold");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, HOLD, 1), "err_done");
        step(mk(3, 0, 1, 0, 1, 3, 0, 1, 0, HOLD, 1), "err_branch");
        chk("tmo.stall_count", 32'(stall_count), 32'd5);
        do_reset("rst_err");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0), "post_err");

        // Reset in the middle of MDU_WAIT discards the pending completion.
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, MST,  0), "mid_start");
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, HOLD, 0), "mid_w1");
        do_reset("rst_mid");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, DEF, 0), "mid_done");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0), "mid_idle");

        // Counter saturation at 3 bits.
        do_reset("rst_sat");
        for (int i = 0; i < 10; i++)
            step(mk(0, 5, 0, 1, 1, 5, 0, 0, 0, LU, 0), $sformatf("sat_lu%0d", i));
        for (int i = 0; i < 9; i++)
            step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, BR, 0), $sformatf("sat_br%0d", i));
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0), "sat_idle");
        chk("sat.stall_count", 32'(stall_count), 32'd7);
        chk("sat.flush_count", 32'(flush_count), 32'd7);

        chk("sb.queue_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core. It sequences pipeline-register write enables and flushes around three events: load-use hazards, taken branches/jumps resolved in EX, and multi-cycle MUL/DIV operations.
- For MUL/DIV it owns a start/done handshake with the MDU, enforces a timeout watchdog and keeps saturating stall/flush statistics.
- The forwarding unit continues to handle all other RAW hazards; this block only stalls when forwarding cannot help.

## Interface
Parameters:
- `MDU_TIMEOUT`, default 64: maximum number of MDU_WAIT cycles without `mdu_done` before error; legal range ≥ 2.
- `CNT_W`, default 32: width of the statistics counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ID_rs1`, `ID_rs2` in 5: source registers of the instruction in ID.
- `ID_use_rs1`, `ID_use_rs2` in 1: the instruction in ID actually reads that source.
- `EX_MemRead` in 1: the instruction in EX is a load.
- `EX_rd` in 5: destination register of the instruction in EX.
- `EX_is_mdu` in 1: the instruction in EX is MUL/DIV/REM.
- `EX_branch_taken` in 1: a branch or jump in EX resolved taken.
- `mdu_done` in 1: MDU result valid; sampled only in MDU_WAIT.
- `PC_Write` out 1: PC update enable.
- `IF_ID_Write` out 1: IF/ID register enable.
- `IF_ID_Flush` out 1: clears IF/ID to a NOP.
- `ID_EX_Write` out 1: ID/EX register enable.
- `ID_EX_Flush` out 1: clears ID/EX to a bubble.
- `EX_MEM_Flush` out 1: inserts a bubble into EX/MEM.
- `mdu_start` out 1: one-cycle start pulse to the MDU.
- `mdu_error` out 1: sticky timeout flag; cleared only by reset.
- `stall_count` out CNT_W: count of stalled cycles.
- `flush_count` out CNT_W: count of flush cycles.

## Operation
States: RUN, MDU_WAIT, ERROR. Reset enters RUN.

Default outputs: all write enables = 1, all flushes = 0, `mdu_start` = 0.

RUN, evaluated in priority order; only the first matching rule applies:
1. `EX_is_mdu`:
   - Assert `mdu_start`.
   - Drive `PC_Write`, `IF_ID_Write`, `ID_EX_Write` = 0 and `EX_MEM_Flush` = 1.
   - Next state MDU_WAIT; clear `wait_cnt`.
2. `EX_branch_taken`: `IF_ID_Flush` = 1 and `ID_EX_Flush` = 1. A branch overrides a simultaneous load-use stall.
3. Load-use hazard: `EX_MemRead` and `EX_rd` != 0 and ((`ID_use_rs1` and `ID_rs1` == `EX_rd`) or (`ID_use_rs2` and `ID_rs2` == `EX_rd`)).
   - Drive `PC_Write` = 0, `IF_ID_Write` = 0, `ID_EX_Flush` = 1.
   - This lasts exactly one cycle, because the bubble resolves the hazard.

MDU_WAIT:
- When `mdu_done` = 1: default outputs (the MDU instruction advances this cycle); next state RUN.
- Otherwise: same hold/bubble outputs as RUN rule 1, but with `mdu_start` = 0. Increment `wait_cnt`.
  - If `wait_cnt` == `MDU_TIMEOUT`-1, set `mdu_error` and go to ERROR next cycle.

ERROR:
- `PC_Write`, `IF_ID_Write`, `ID_EX_Write` = 0; `EX_MEM_Flush` = 1.
- `mdu_done` is ignored.
- The block stays in ERROR until `rst`.

Statistics counters:
- `stall_count` increments on every cycle in RUN or MDU_WAIT where `PC_Write` = 0. It does not count in ERROR.
- `flush_count` increments on every cycle where `IF_ID_Flush` = 1.
- Both counters saturate at all-ones; there is no wrap-around.

## Timing
- All control outputs are combinational from state and current inputs: zero latency within the cycle.
- State, `wait_cnt`, `mdu_error` and the counters are registered.
- Reset values: state RUN, `wait_cnt` 0, `mdu_error` 0, `stall_count` 0, `flush_count` 0.
  - With all inputs at 0 during and after reset, outputs read `PC_Write` = `IF_ID_Write` = `ID_EX_Write` = 1, all flushes = 0, `mdu_start` = 0.
- `mdu_start` is high for exactly one cycle per MDU instruction.
- `mdu_done` arriving in RUN (including the start cycle) is ignored.
- MDU stall length: if the start is in cycle t and the first `mdu_done` is in cycle t+N, then N ≥ 1. The pipeline is held in cycles t through t+N-1 and advances in t+N.
- Timeout: with no done, ERROR is entered at cycle t+1+`MDU_TIMEOUT`, after exactly `MDU_TIMEOUT` WAIT cycles.
- Asserting `rst` mid-MDU_WAIT or in ERROR returns to RUN immediately. The counters and `mdu_error` clear, and any outstanding MDU completion is discarded.

## Test plan
- Reset, then load x5 in EX (`EX_MemRead`=1, `EX_rd`=5) with `ID_rs2`=5 and `ID_use_rs2`=1 -> exactly one cycle of `PC_Write`=0, `IF_ID_Write`=0, `ID_EX_Flush`=1; `stall_count`=1.
- Load with `EX_rd`=0 and `ID_rs1`=0 used -> no stall. Load with `EX_rd`=7 and `ID_rs1`=7 but `ID_use_rs1`=0 -> no stall.
- Load-use hazard and `EX_branch_taken`=1 in the same cycle -> `IF_ID_Flush`=`ID_EX_Flush`=1, `PC_Write`=1; `flush_count`=1, `stall_count`=0.
- `EX_is_mdu` with `mdu_done` 4 cycles after start -> `mdu_start` pulses once; holds and `EX_MEM_Flush` last 4 cycles; release on the done cycle; `stall_count`=4. Also `mdu_done` held high during the start cycle -> it is ignored.
- `MDU_TIMEOUT`=4 and `mdu_done` never asserts -> ERROR after 4 WAIT cycles, `mdu_error`=1, pipeline frozen. A later `mdu_done` changes nothing. `rst` clears to the reset values.
- `CNT_W`=3 with 10 load-use stalls -> `stall_count` saturates at 7.
